// File: rtl/hazard_if.sv
// Hazard-unit bundle between the 5-stage datapath and hazard_ctrl.
// The master modport is the datapath side; the slave modport is the hazard unit.
interface hazard_if;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic       memread_E, regwrite_M, regwrite_W, mispredict_E, mem_busy;
  logic       start, stallF, stallD, stallE, stallM, flushD, flushE;
  logic [1:0] fwdA_E, fwdB_E;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
    output memread_E, regwrite_M, regwrite_W, mispredict_E, mem_busy,
    input  start, stallF, stallD, stallE, stallM, flushD, flushE, fwdA_E, fwdB_E
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
    input  memread_E, regwrite_M, regwrite_W, mispredict_E, mem_busy,
    output start, stallF, stallD, stallE, stallM, flushD, flushE, fwdA_E, fwdB_E
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer / hazard unit: boot hold, load-use stall, mispredict flush, dmem wait, EX forwarding.
// Optional HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt performance counters.
module hazard_ctrl #(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic           clk,
  input  logic           rst,
  hazard_if.slave        hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] MWAIT = 2'd2;

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] boot_cnt_q, boot_cnt_d;
  logic       load_use;

  // ---------------------------------------------------------------------------
  // Next-state logic; the counter saturates once boot completes.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + 8'd1;
        if (boot_cnt_q == BOOT_LAST) state_d = RUN;
      end
      RUN:     if (hz.mem_busy)  state_d = MWAIT;
      MWAIT:   if (!hz.mem_busy) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q    <= BOOT;
      boot_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control decode, highest priority first. x0 is never a load-use target.
  // ---------------------------------------------------------------------------
  assign load_use = hz.memread_E && (hz.rd_E != 5'd0) &&
                    ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));

  always_comb begin
    hz.start  = 1'b0;
    hz.stallF = 1'b0;
    hz.stallD = 1'b0;
    hz.stallE = 1'b0;
    hz.stallM = 1'b0;
    hz.flushD = 1'b0;
    hz.flushE = 1'b0;
    if (state_q == BOOT) begin
      hz.start  = 1'b1;
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.stallM = 1'b1;
    end else if (hz.mem_busy) begin
      // EX is frozen, so a pending mispredict persists until memory is ready.
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.stallM = 1'b1;
    end else if (hz.mispredict_E) begin
      hz.flushD = 1'b1;
      hz.flushE = 1'b1;
    end else if (load_use) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.flushE = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding: MEM result is newer than WB, so it wins a double match.
  // Held at regfile select while reset is asserted.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (hz.regwrite_M && (hz.rd_M != 5'd0) && (hz.rd_M == rs))      fwd_sel = 2'b10;
    else if (hz.regwrite_W && (hz.rd_W != 5'd0) && (hz.rd_W == rs)) fwd_sel = 2'b01;
    else                                                            fwd_sel = 2'b00;
  endfunction

  always_comb begin
    hz.fwdA_E = 2'b00;
    hz.fwdB_E = 2'b00;
    if (!rst) begin
      hz.fwdA_E = fwd_sel(hz.rs1_E);
      hz.fwdB_E = fwd_sel(hz.rs2_E);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != BOOT) begin
      if (hz.stallF)               stall_cnt_d = stall_cnt_q + 1'b1;
      if (hz.flushD || hz.flushE)  flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  wire [CNT_W-1:0] unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: boot hold, load-use, mispredict, dmem wait, forwarding.
// Perf-counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  hazard_if hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  hazard_ctrl #(.BOOT_CYCLES(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hz(hz), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
  hazard_ctrl #(.BOOT_CYCLES(4), .CNT_W(32)) dut (.clk(clk), .rst(rst), .hz(hz));
`endif

  // {start, stallF, stallD, stallE, stallM, flushD, flushE}
  logic [6:0] ctrl;
  assign ctrl = {hz.start, hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushD, hz.flushE};

  localparam logic [6:0] C_BOOT  = 7'b1111100;
  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_LUSE  = 7'b0110001;
  localparam logic [6:0] C_FLUSH = 7'b0000011;
  localparam logic [6:0] C_WAIT  = 7'b0111100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after posedge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    hz.rs1_D = '0; hz.rs2_D = '0; hz.rs1_E = '0; hz.rs2_E = '0;
    hz.rd_E = '0; hz.rd_M = '0; hz.rd_W = '0;
    hz.memread_E = 1'b0; hz.regwrite_M = 1'b0; hz.regwrite_W = 1'b0;
    hz.mispredict_E = 1'b0; hz.mem_busy = 1'b0;
  endtask

  task automatic release_and_boot(input string tag);
    rst = 1'b0;
    #1 check({tag, "_rel"}, 32'(ctrl), 32'(C_BOOT));
    for (int i = 1; i <= 3; i++) begin
      tick();
      #1 check($sformatf("%s_boot%0d", tag, i), 32'(ctrl), 32'(C_BOOT));
    end
    tick();
    #1 check({tag, "_run"}, 32'(ctrl), 32'(C_IDLE));
  endtask

  initial begin
    clear_inputs();
    // Reset with a live forwarding match: outputs must still be the reset values.
    hz.rs1_E = 5'd3; hz.rd_M = 5'd3; hz.regwrite_M = 1'b1;
    tick(); tick();
    #1 check("rst_ctrl", 32'(ctrl), 32'(C_BOOT));
    check("rst_fwdA", 32'(hz.fwdA_E), 32'd0);
    clear_inputs();
    release_and_boot("por");

    // Forwarding priority and x0 suppression.
    hz.rs1_E = 5'd3; hz.rd_M = 5'd3; hz.regwrite_M = 1'b1; hz.rd_W = 5'd3; hz.regwrite_W = 1'b1;
    #1 check("fwdA_mem", 32'(hz.fwdA_E), 32'd2);
    hz.rd_M = 5'd0;
    #1 check("fwdA_wb", 32'(hz.fwdA_E), 32'd1);
    hz.rs1_E = 5'd0; hz.rd_W = 5'd0;
    #1 check("fwdA_x0", 32'(hz.fwdA_E), 32'd0);
    hz.rs2_E = 5'd4; hz.rd_M = 5'd4; hz.regwrite_M = 1'b0; hz.rd_W = 5'd4; hz.regwrite_W = 1'b1;
    #1 check("fwdB_wb_nowrM", 32'(hz.fwdB_E), 32'd1);
    clear_inputs();

    // Load-use: one stall cycle, then the load has moved to MEM.
    hz.memread_E = 1'b1; hz.rd_E = 5'd5; hz.rs2_D = 5'd5;
    #1 check("luse_stall", 32'(ctrl), 32'(C_LUSE));
    tick();
    hz.memread_E = 1'b0; hz.rd_M = 5'd5;
    #1 check("luse_after", 32'(ctrl), 32'(C_IDLE));
    clear_inputs();
    hz.memread_E = 1'b1; hz.rd_E = 5'd0; hz.rs1_D = 5'd0;
    #1 check("luse_x0", 32'(ctrl), 32'(C_IDLE));
    clear_inputs();

    // Mispredict overrides load-use.
    hz.mispredict_E = 1'b1; hz.memread_E = 1'b1; hz.rd_E = 5'd7; hz.rs1_D = 5'd7;
    #1 check("mp_over_luse", 32'(ctrl), 32'(C_FLUSH));
    tick();
    clear_inputs();

    // Memory wait freezes a pending mispredict, acted on once ready.
    hz.mem_busy = 1'b1; hz.mispredict_E = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1 check($sformatf("mwait%0d", i), 32'(ctrl), 32'(C_WAIT));
      tick();
    end
    hz.mem_busy = 1'b0;
    #1 check("mwait_release", 32'(ctrl), 32'(C_FLUSH));
    tick();
    hz.mispredict_E = 1'b0;
    #1 check("mwait_idle", 32'(ctrl), 32'(C_IDLE));
    tick();

    // Asynchronous reset pulse mid-RUN.
    rst = 1'b1;
    #1 check("midrun_rst", 32'(ctrl), 32'(C_BOOT));
    tick();
    release_and_boot("midrun");

`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall0", stall_cnt, 32'd0);
    check("perf_flush0", flush_cnt, 32'd0);
    hz.memread_E = 1'b1; hz.rd_E = 5'd5; hz.rs2_D = 5'd5;
    tick();
    clear_inputs();
    hz.mispredict_E = 1'b1; hz.memread_E = 1'b1; hz.rd_E = 5'd7; hz.rs1_D = 5'd7;
    tick();
    clear_inputs();
    #1 check("perf_stall", stall_cnt, 32'd1);
    check("perf_flush", flush_cnt, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
